// File: rtl/mips_cpu_mem_arbiter.sv
// mips_cpu_mem_arbiter: shares one single-port Avalon-style memory between
// the CPU instruction-fetch port and the data-access port.
// Latency: request seen in cycle 0, command on mem_* in cycle 1, stall low in cycle 2.
// Backpressure: mem_waitrequest holds the command; requesters are stalled until their DONE cycle.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   instr_read/address           fetch request (stall-based master)
//   instr_readdata/stall         fetched word, fetch-not-complete flag
//   data_read/write/address      data request (stall-based master)
//   data_writedata/byteenable    store data and byte lanes
//   data_readdata/stall          load result, data-not-complete flag
//   mem_*                        Avalon-style memory master
//
// Optional feature: define MEM_ARB_RR_EN to alternate between ports when both
// are pending in IDLE. Without it, data always beats fetch.
module mips_cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                instr_read,
    input  logic [ADDR_W-1:0]   instr_address,
    output logic [DATA_W-1:0]   instr_readdata,
    output logic                instr_stall,

    input  logic                data_read,
    input  logic                data_write,
    input  logic [ADDR_W-1:0]   data_address,
    input  logic [DATA_W-1:0]   data_writedata,
    input  logic [DATA_W/8-1:0] data_byteenable,
    output logic [DATA_W-1:0]   data_readdata,
    output logic                data_stall,

    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata,
    input  logic                mem_waitrequest
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_I = 3'd1,
        GRANT_D = 3'd2,
        DONE_I  = 3'd3,
        DONE_D  = 3'd4
    } state_t;

    state_t state;

    logic fetch_pend;
    logic data_pend;
    logic pick_data;

    assign fetch_pend = instr_read;
    assign data_pend  = data_read | data_write;

`ifdef MEM_ARB_RR_EN
    // 0 = fetch was granted last, 1 = data was granted last.
    logic last_grant;

    // On contention the port not served last wins; a lone request always wins.
    assign pick_data = data_pend & (~fetch_pend | ~last_grant);
`else
    assign pick_data = data_pend;
`endif

    // Stalls are combinational so a withdrawn request never sees a
    // completion pulse and an idle port never stalls.
    assign instr_stall = instr_read & (state != DONE_I);
    assign data_stall  = data_pend  & (state != DONE_D);

    // The memory command is registered at grant time and cleared when the
    // memory accepts it, so the bus is quiet in IDLE/DONE and the command
    // stays stable for every wait-state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            mem_address    <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            instr_readdata <= '0;
            data_readdata  <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_data) begin
                        state          <= GRANT_D;
                        mem_address    <= data_address;
                        mem_byteenable <= data_byteenable;
                        mem_writedata  <= data_writedata;
                        mem_write      <= data_write;
                        // A simultaneous read+write is treated as a write.
                        mem_read       <= data_read & ~data_write;
`ifdef MEM_ARB_RR_EN
                        last_grant     <= 1'b1;
`endif
                    end else if (fetch_pend) begin
                        state          <= GRANT_I;
                        mem_address    <= instr_address;
                        mem_byteenable <= {BE_W{1'b1}};
                        mem_writedata  <= '0;
                        mem_write      <= 1'b0;
                        mem_read       <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_grant     <= 1'b0;
`endif
                    end
                end

                GRANT_I: begin
                    if (!mem_waitrequest) begin
                        instr_readdata <= mem_readdata;
                        state          <= DONE_I;
                        mem_address    <= '0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_writedata  <= '0;
                        mem_byteenable <= '0;
                    end
                end

                GRANT_D: begin
                    if (!mem_waitrequest) begin
                        // Stores leave the load register untouched.
                        if (mem_read) begin
                            data_readdata <= mem_readdata;
                        end
                        state          <= DONE_D;
                        mem_address    <= '0;
                        mem_read       <= 1'b0;
                        mem_write      <= 1'b0;
                        mem_writedata  <= '0;
                        mem_byteenable <= '0;
                    end
                end

                DONE_I, DONE_D: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench for mips_cpu_mem_arbiter: reset, fetch, contention,
// wait-stated store, read+write collision and mid-transaction reset.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_stall;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_stall;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    int n_chk  = 0;
    int n_fail = 0;

    mips_cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_read      (instr_read),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .instr_stall     (instr_stall),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_stall      (data_stall),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        second_is_data;
    logic [31:0] exp_drd;

    initial begin
`ifdef MEM_ARB_RR_EN
        second_is_data = 1'b0;
`else
        second_is_data = 1'b1;
`endif

        rst_n           = 1'b0;
        instr_read      = 1'b1;
        instr_address   = 32'h0000_0040;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_writedata  = 32'h0;
        data_byteenable = 4'h0;
        mem_readdata    = 32'h1111_1111;
        mem_waitrequest = 1'b0;

        // ---- Reset held with a fetch asserted ----
        step(); step(); step();
        check("rst_mem_read",  {31'b0, mem_read}, 32'd0);
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_address, 32'd0);
        check("rst_mem_wdata", mem_writedata, 32'd0);
        check("rst_mem_be",    {28'b0, mem_byteenable}, 32'd0);
        check("rst_irdata",    instr_readdata, 32'd0);
        check("rst_drdata",    data_readdata, 32'd0);
        check("rst_istall",    {31'b0, instr_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_istall",    {31'b0, instr_stall}, 32'd1);
        step();
        check("rel_c1_read",   {31'b0, mem_read}, 32'd1);
        check("rel_c1_addr",   mem_address, 32'h0000_0040);
        check("rel_c1_istall", {31'b0, instr_stall}, 32'd1);
        step();
        check("rel_c2_istall", {31'b0, instr_stall}, 32'd0);
        check("rel_c2_irdata", instr_readdata, 32'h1111_1111);
        instr_read = 1'b0;
        step();

        // ---- Fetch, zero wait states ----
        instr_read    = 1'b1;
        instr_address = 32'hBFC0_0000;
        mem_readdata  = 32'h2402_0005;
        #1;
        check("f_c0_read",   {31'b0, mem_read}, 32'd0);
        check("f_c0_istall", {31'b0, instr_stall}, 32'd1);
        step();
        check("f_c1_read",   {31'b0, mem_read}, 32'd1);
        check("f_c1_write",  {31'b0, mem_write}, 32'd0);
        check("f_c1_addr",   mem_address, 32'hBFC0_0000);
        check("f_c1_be",     {28'b0, mem_byteenable}, 32'hF);
        check("f_c1_istall", {31'b0, instr_stall}, 32'd1);
        check("f_c1_dstall", {31'b0, data_stall}, 32'd0);
        step();
        check("f_c2_read",   {31'b0, mem_read}, 32'd0);
        check("f_c2_istall", {31'b0, instr_stall}, 32'd0);
        check("f_c2_irdata", instr_readdata, 32'h2402_0005);
        check("f_c2_addr",   mem_address, 32'd0);
        instr_read = 1'b0;
        step();
        check("f_c3_read",   {31'b0, mem_read}, 32'd0);

        // ---- Contention: fetch and load in the same cycle ----
        instr_read      = 1'b1;
        instr_address   = 32'h0000_0100;
        data_read       = 1'b1;
        data_address    = 32'h0000_0200;
        data_byteenable = 4'hF;
        mem_readdata    = 32'hCAFE_F00D;
        step();
        check("c_c1_addr",   mem_address, 32'h0000_0200);
        check("c_c1_read",   {31'b0, mem_read}, 32'd1);
        check("c_c1_istall", {31'b0, instr_stall}, 32'd1);
        check("c_c1_dstall", {31'b0, data_stall}, 32'd1);
        step();
        check("c_c2_dstall", {31'b0, data_stall}, 32'd0);
        check("c_c2_istall", {31'b0, instr_stall}, 32'd1);
        check("c_c2_drdata", data_readdata, 32'hCAFE_F00D);
        // Data issues its next load immediately: a second contending pair.
        data_address = 32'h0000_0300;
        step();
        check("c_c3_read",   {31'b0, mem_read}, 32'd0);
        mem_readdata = 32'h1234_5678;
        step();
        check("c_c4_addr",   mem_address, second_is_data ? 32'h0000_0300 : 32'h0000_0100);
        check("c_c4_read",   {31'b0, mem_read}, 32'd1);
        step();
        check("c_c5_istall", {31'b0, instr_stall}, {31'b0, second_is_data});
        check("c_c5_dstall", {31'b0, data_stall},  {31'b0, ~second_is_data});
        check("c_c5_rdata",  second_is_data ? data_readdata : instr_readdata, 32'h1234_5678);
        if (second_is_data) data_read = 1'b0;
        else                instr_read = 1'b0;
        step();
        mem_readdata = 32'h0BAD_C0DE;
        step();
        check("c_c7_addr",   mem_address, second_is_data ? 32'h0000_0100 : 32'h0000_0300);
        check("c_c7_read",   {31'b0, mem_read}, 32'd1);
        step();
        check("c_c8_rdata",  second_is_data ? instr_readdata : data_readdata, 32'h0BAD_C0DE);
        check("c_c8_stall",  {31'b0, instr_stall | data_stall}, 32'd0);
        instr_read = 1'b0;
        data_read  = 1'b0;
        exp_drd    = second_is_data ? 32'h1234_5678 : 32'h0BAD_C0DE;
        step();

        // ---- Store with two wait states ----
        data_write      = 1'b1;
        data_address    = 32'h0000_0010;
        data_writedata  = 32'hDEAD_BEEF;
        data_byteenable = 4'b0011;
        mem_waitrequest = 1'b1;
        mem_readdata    = 32'h5555_5555;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("s_c%0d_write", c), {31'b0, mem_write}, 32'd1);
            check($sformatf("s_c%0d_read", c),  {31'b0, mem_read}, 32'd0);
            check($sformatf("s_c%0d_addr", c),  mem_address, 32'h0000_0010);
            check($sformatf("s_c%0d_wdata", c), mem_writedata, 32'hDEAD_BEEF);
            check($sformatf("s_c%0d_be", c),    {28'b0, mem_byteenable}, 32'h3);
            check($sformatf("s_c%0d_dstall", c), {31'b0, data_stall}, 32'd1);
            if (c == 3) mem_waitrequest = 1'b0;
        end
        step();
        check("s_c4_write",  {31'b0, mem_write}, 32'd0);
        check("s_c4_dstall", {31'b0, data_stall}, 32'd0);
        check("s_c4_drdata", data_readdata, exp_drd);
        data_write = 1'b0;
        step();

        // ---- Read and write together: write wins ----
        data_read       = 1'b1;
        data_write      = 1'b1;
        data_address    = 32'h0000_0020;
        data_writedata  = 32'hA5A5_A5A5;
        data_byteenable = 4'hF;
        mem_readdata    = 32'h7777_7777;
        step();
        check("rw_c1_write",  {31'b0, mem_write}, 32'd1);
        check("rw_c1_read",   {31'b0, mem_read}, 32'd0);
        check("rw_c1_wdata",  mem_writedata, 32'hA5A5_A5A5);
        step();
        check("rw_c2_dstall", {31'b0, data_stall}, 32'd0);
        check("rw_c2_read",   {31'b0, mem_read}, 32'd0);
        check("rw_c2_drdata", data_readdata, exp_drd);
        data_read  = 1'b0;
        data_write = 1'b0;
        step();

        // ---- Asynchronous reset during a stalled store ----
        data_write      = 1'b1;
        data_address    = 32'h0000_0044;
        data_writedata  = 32'h0102_0304;
        mem_waitrequest = 1'b1;
        step();
        check("ar_c1_write", {31'b0, mem_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_write_drop", {31'b0, mem_write}, 32'd0);
        check("ar_addr_drop",  mem_address, 32'd0);
        check("ar_dstall",     {31'b0, data_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        // Store still requested, memory still waiting: no completion may appear.
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("ar_post%0d_dstall", c), {31'b0, data_stall}, 32'd1);
        end
        check("ar_regrant_write", {31'b0, mem_write}, 32'd1);
        mem_waitrequest = 1'b0;
        step();
        check("ar_done_dstall", {31'b0, data_stall}, 32'd0);
        data_write = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
